// File: rtl/alu_sequencer.sv
// Multi-cycle ALU issue sequencer with internal register file.
// Optional: ALU_SEQ_R0_ZERO_EN makes R0 a hardwired zero.
`ifndef WORDSIZE
`define WORDSIZE 32
`endif
`ifndef ALUOPSIZE
`define ALUOPSIZE 3
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 3'd0
`endif

module alu_sequencer #(
    parameter  int REG_AW  = 3,
    localparam int INSTR_W = `ALUOPSIZE + 3 * REG_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  reg_we,
    input  logic [REG_AW-1:0]     reg_waddr,
    input  logic [`WORDSIZE-1:0]  reg_wdata,
    output logic [`WORDSIZE-1:0]  alu_a,
    output logic [`WORDSIZE-1:0]  alu_b,
    output logic [`ALUOPSIZE-1:0] alu_op,
    input  logic [`WORDSIZE-1:0]  alu_result,
    input  logic                  zero_flag,
    output logic                  done,
    output logic [`WORDSIZE-1:0]  wb_data,
    output logic                  zero_out,
    input  logic [REG_AW-1:0]     dbg_addr,
    output logic [`WORDSIZE-1:0]  dbg_data
);

    localparam int NREGS = 2 ** REG_AW;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WB
    } state_t;

    state_t                 state;
    logic [`WORDSIZE-1:0]   rf [NREGS];
    logic [`ALUOPSIZE-1:0]  op_q;
    logic [REG_AW-1:0]      rd_q;
    logic [REG_AW-1:0]      rs_q;
    logic [REG_AW-1:0]      rt_q;
    logic [`WORDSIZE-1:0]   res;
    logic                   zf;

    function automatic logic [`WORDSIZE-1:0] rd_reg(input logic [REG_AW-1:0] a);
`ifdef ALU_SEQ_R0_ZERO_EN
        return (a == '0) ? '0 : rf[a];
`else
        return rf[a];
`endif
    endfunction

    function automatic logic wr_ok(input logic [REG_AW-1:0] a);
`ifdef ALU_SEQ_R0_ZERO_EN
        return a != '0;
`else
        return (a == a);
`endif
    endfunction

    assign instr_ready = (state == IDLE);
    assign dbg_data    = rd_reg(dbg_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= `ALU_OP_ADD;
            done     <= 1'b0;
            wb_data  <= '0;
            zero_out <= 1'b0;
            op_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            res      <= '0;
            zf       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // External loads commit here so a same-cycle accept reads them in READ
                    if (reg_we && wr_ok(reg_waddr)) rf[reg_waddr] <= reg_wdata;
                    if (instr_valid) begin
                        {op_q, rd_q, rs_q, rt_q} <= instr;
                        state <= READ;
                    end
                end
                READ: begin
                    alu_a  <= rd_reg(rs_q);
                    alu_b  <= rd_reg(rt_q);
                    alu_op <= op_q;
                    state  <= EXEC;
                end
                EXEC: begin
                    res   <= alu_result;
                    zf    <= zero_flag;
                    state <= WB;
                end
                WB: begin
                    if (wr_ok(rd_q)) rf[rd_q] <= res;
                    wb_data  <= res;
                    zero_out <= zf;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer with a behavioural ALU.
// Expectations for R0 depend on ALU_SEQ_R0_ZERO_EN.
`ifndef WORDSIZE
`define WORDSIZE 32
`endif
`ifndef ALUOPSIZE
`define ALUOPSIZE 3
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 3'd0
`endif

module tb_alu_sequencer;

    localparam int AW = 3;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  instr_valid = 1'b0;
    logic                  instr_ready;
    logic [11:0]           instr = '0;
    logic                  reg_we = 1'b0;
    logic [AW-1:0]         reg_waddr = '0;
    logic [`WORDSIZE-1:0]  reg_wdata = '0;
    logic [`WORDSIZE-1:0]  alu_a;
    logic [`WORDSIZE-1:0]  alu_b;
    logic [`ALUOPSIZE-1:0] alu_op;
    logic [`WORDSIZE-1:0]  alu_result;
    logic                  zero_flag;
    logic                  done;
    logic [`WORDSIZE-1:0]  wb_data;
    logic                  zero_out;
    logic [AW-1:0]         dbg_addr = '0;
    logic [`WORDSIZE-1:0]  dbg_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            default: alu_result = '0;
        endcase
        zero_flag = (alu_result == '0);
    end

    alu_sequencer #(.REG_AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .reg_we      (reg_we),
        .reg_waddr   (reg_waddr),
        .reg_wdata   (reg_wdata),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .zero_flag   (zero_flag),
        .done        (done),
        .wb_data     (wb_data),
        .zero_out    (zero_out),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [AW-1:0] a,
                           input logic [31:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
        reg_we = 1'b1;
        reg_waddr = a;
        reg_wdata = d;
        tick();
        reg_we = 1'b0;
    endtask

    // Offer an instruction and return after its accepting edge
    task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            tick();
            n++;
        end
        if (!instr_ready) check("accept_timeout", 32'(instr_ready), 32'd1);
        instr = {op, rd, rs, rt};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt, input logic [31:0] ea,
                       input logic [31:0] eb, input logic [31:0] er,
                       input logic ez, input logic [31:0] erd);
        issue(op, rd, rs, rt);
        check({tag, "_rdy0"}, 32'(instr_ready), 32'd0);
        tick();
        check({tag, "_a"}, alu_a, ea);
        check({tag, "_b"}, alu_b, eb);
        check({tag, "_op"}, 32'(alu_op), 32'(op));
        tick();
        check({tag, "_done0"}, 32'(done), 32'd0);
        tick();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_wb"}, wb_data, er);
        check({tag, "_zf"}, 32'(zero_out), 32'(ez));
        chk_reg({tag, "_rd"}, rd, erd);
    endtask

    initial begin
        int lows;
        logic [31:0] e_r0a;
        logic [31:0] e_r0res;
        logic [31:0] e_r0rd;

        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_op", 32'(alu_op), 32'(`ALU_OP_ADD));
        check("rst_a", alu_a, 32'd0);
        check("rst_wb", wb_data, 32'd0);
        chk_reg("rst_r1", 3'd1, 32'd0);

        load(3'd1, 32'd5);
        load(3'd2, 32'd3);
        run("add", OP_ADD, 3'd3, 3'd1, 3'd2, 32'd5, 32'd3, 32'd8, 1'b0, 32'd8);
        run("sub", OP_SUB, 3'd4, 3'd1, 3'd1, 32'd5, 32'd5, 32'd0, 1'b1, 32'd0);
        tick();
        check("done_pulse", 32'(done), 32'd0);

        // Back-to-back AND then dependent OR with instr_valid held high
        instr = {OP_AND, 3'd5, 3'd1, 3'd2};
        instr_valid = 1'b1;
        tick();
        instr = {OP_OR, 3'd6, 3'd5, 3'd1};
        lows = 0;
        for (int i = 0; i < 3; i++) begin
            if (!instr_ready) lows++;
            tick();
        end
        check("b2b_low1", 32'(lows), 32'd3);
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_wb1", wb_data, 32'd1);
        check("b2b_rdy1", 32'(instr_ready), 32'd1);
        tick();
        instr_valid = 1'b0;
        lows = 0;
        for (int i = 0; i < 3; i++) begin
            if (!instr_ready) lows++;
            tick();
        end
        check("b2b_low2", 32'(lows), 32'd3);
        check("b2b_done2", 32'(done), 32'd1);
        check("b2b_wb2", wb_data, 32'd5);
        chk_reg("b2b_r5", 3'd5, 32'd1);
        chk_reg("b2b_r6", 3'd6, 32'd5);

        // Load while busy is dropped
        issue(OP_ADD, 3'd7, 3'd1, 3'd2);
        tick();
        reg_we = 1'b1;
        reg_waddr = 3'd1;
        reg_wdata = 32'd9;
        tick();
        reg_we = 1'b0;
        tick();
        check("busy_we_wb", wb_data, 32'd8);
        chk_reg("busy_we_r1", 3'd1, 32'd5);

        // Load in the accept cycle is seen by READ
        reg_we = 1'b1;
        reg_waddr = 3'd1;
        reg_wdata = 32'd9;
        issue(OP_ADD, 3'd3, 3'd1, 3'd2);
        reg_we = 1'b0;
        tick();
        check("same_we_a", alu_a, 32'd9);
        tick();
        tick();
        check("same_we_wb", wb_data, 32'd12);
        chk_reg("same_we_r3", 3'd3, 32'd12);

`ifdef ALU_SEQ_R0_ZERO_EN
        e_r0a = 32'd0;
        e_r0res = 32'd3;
        e_r0rd = 32'd0;
`else
        e_r0a = 32'd7;
        e_r0res = 32'd10;
        e_r0rd = 32'd10;
`endif
        load(3'd0, 32'd7);
        run("r0", OP_ADD, 3'd0, 3'd0, 3'd2, e_r0a, 32'd3, e_r0res, 1'b0, e_r0rd);

        // Reset in EXEC aborts the instruction
        issue(OP_SUB, 3'd7, 3'd1, 3'd2);
        tick();
        check("abort_op", 32'(alu_op), 32'(OP_SUB));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ready", 32'(instr_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_op_rst", 32'(alu_op), 32'(`ALU_OP_ADD));
        for (int i = 0; i < 8; i++) chk_reg("abort_reg", AW'(i), 32'd0);
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) lows++;
        end
        check("abort_no_wb", 32'(lows), 32'd0);
        check("abort_wbdata", wb_data, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule
